// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN post-processing stages: default geometry,
// the sample type, and the signed max helpers used by the pooling lanes.
package cnn_pkg;

    localparam int CNN_DATA_W = 12;
    localparam int CNN_MAP_W  = 3;
    localparam int CNN_MAP_H  = 3;

    // Compare width wide enough for any legal DATA_W. Lanes sign-extend
    // into it, so one helper serves every lane width.
    localparam int CNN_CMP_W  = 32;

    typedef logic signed [CNN_DATA_W-1:0] cnn_sample_t;
    typedef logic signed [CNN_CMP_W-1:0]  cnn_wide_t;

    function automatic cnn_wide_t max2(input cnn_wide_t a, input cnn_wide_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic cnn_wide_t max4(input cnn_wide_t a, input cnn_wide_t b,
                                       input cnn_wide_t c, input cnn_wide_t d);
        return max2(max2(a, b), max2(c, d));
    endfunction

endpackage

// File: rtl/maxpool_lane.sv
// One channel of the 2x2 stride-1 max-pool: optional ReLU (CNN_POOL_RELU_EN),
// previous-row line buffer, left/diag registers and the four-way signed max.
module maxpool_lane
    import cnn_pkg::*;
#(
    parameter int  DATA_W = CNN_DATA_W,
    parameter int  MAP_W  = CNN_MAP_W,
    localparam int COL_W  = $clog2(MAP_W)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     load,
    input  logic [COL_W-1:0]         col,
    input  logic signed [DATA_W-1:0] sample,
    output logic signed [DATA_W-1:0] pool
);

    logic signed [DATA_W-1:0] line_buf [MAP_W];
    logic signed [DATA_W-1:0] left_q;
    logic signed [DATA_W-1:0] diag_q;
    logic signed [DATA_W-1:0] r;
    logic signed [DATA_W-1:0] above;

    always_comb begin
`ifdef CNN_POOL_RELU_EN
        r = sample[DATA_W-1] ? '0 : sample;
`else
        r = sample;
`endif
    end

    // Window is {diag, above} over {left, r}; only meaningful when row,col >= 1.
    always_comb begin
        above = line_buf[col];
        pool  = DATA_W'(max4(CNN_CMP_W'(diag_q), CNN_CMP_W'(above),
                             CNN_CMP_W'(left_q), CNN_CMP_W'(r)));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < MAP_W; i++) begin
                line_buf[i] <= '0;
            end
            left_q <= '0;
            diag_q <= '0;
        end else if (load) begin
            diag_q        <= above;
            line_buf[col] <= r;
            left_q        <= r;
        end
    end

endmodule

// File: rtl/relu_maxpool_2x2.sv
// Streaming ReLU (CNN_POOL_RELU_EN) + 2x2 stride-1 max-pool over a two-channel
// MAP_H x MAP_W feature map arriving in raster order; one pooled pair per window.
module relu_maxpool_2x2
    import cnn_pkg::*;
#(
    parameter int DATA_W = CNN_DATA_W,
    parameter int MAP_W  = CNN_MAP_W,
    parameter int MAP_H  = CNN_MAP_H
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_ch1,
    input  logic signed [DATA_W-1:0] in_ch2,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_ch1,
    output logic signed [DATA_W-1:0] out_ch2,
    output logic                     frame_done
);

    localparam int COL_W = $clog2(MAP_W);
    localparam int ROW_W = $clog2(MAP_H);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             in_fire;
    logic             last_col;
    logic             last_row;
    logic             produce;
    logic signed [DATA_W-1:0] pool1;
    logic signed [DATA_W-1:0] pool2;

    // Handshake: a transfer happens on a side when its valid and ready are both
    // high at the rising edge. Valid never depends on ready; in_ready follows
    // out_ready combinationally so a full output register can drain and reload
    // in the same cycle, and is held low throughout reset.
    assign in_ready = reset_n && (!out_valid || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign last_col = (col == COL_W'(MAP_W - 1));
    assign last_row = (row == ROW_W'(MAP_H - 1));
    assign produce  = (row != '0) && (col != '0);

    maxpool_lane #(.DATA_W(DATA_W), .MAP_W(MAP_W)) u_lane1 (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (in_fire),
        .col     (col),
        .sample  (in_ch1),
        .pool    (pool1)
    );

    maxpool_lane #(.DATA_W(DATA_W), .MAP_W(MAP_W)) u_lane2 (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (in_fire),
        .col     (col),
        .sample  (in_ch2),
        .pool    (pool2)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            col <= '0;
            row <= '0;
        end else if (in_fire) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            out_ch1    <= '0;
            out_ch2    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= in_fire && last_col && last_row;
            if (in_fire && produce) begin
                out_valid <= 1'b1;
                out_ch1   <= pool1;
                out_ch2   <= pool2;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_relu_maxpool_2x2.sv
// Bench for relu_maxpool_2x2: table-driven frames, hand-written corner
// sequences and randomized frames checked against a window-max reference.
module tb_relu_maxpool_2x2;

    localparam int W    = 12;
    localparam int MW   = 3;
    localparam int MH   = 3;
    localparam int NPIX = MW * MH;
    localparam int NOUT = (MW - 1) * (MH - 1);
    localparam int NV   = 4;

`ifdef CNN_POOL_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    typedef logic [NPIX-1:0][W-1:0] frame_t;
    typedef logic [NOUT-1:0][W-1:0] result_t;
    typedef struct packed {
        frame_t  ch1;
        frame_t  ch2;
        result_t exp1;
        result_t exp2;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic out_valid;
    logic out_ready = 1'b0;
    logic frame_done;
    logic signed [W-1:0] in_ch1 = '0;
    logic signed [W-1:0] in_ch2 = '0;
    logic signed [W-1:0] out_ch1;
    logic signed [W-1:0] out_ch2;

    int checks = 0;
    int errors = 0;
    int frames_seen = 0;
    int ready_mode = 1;  // 0 hold low, 1 always high, 2 random
    bit sender_done;
    logic [2*W-1:0] got_q[$];
    logic [2*W-1:0] exp_q[$];
    vec_t vecs[NV];

    always #5 clk = ~clk;

    relu_maxpool_2x2 #(.DATA_W(W), .MAP_W(MW), .MAP_H(MH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ch1     (in_ch1),
        .in_ch2     (in_ch2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ch1    (out_ch1),
        .out_ch2    (out_ch2),
        .frame_done (frame_done)
    );

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Consumer: out_ready only changes just after a rising edge.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor: values seen at the falling edge are what the next rising edge samples.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) got_q.push_back({out_ch1, out_ch2});
        if (reset_n && frame_done) begin
            frames_seen++;
            check("frame_done_aligned_out_valid", int'(out_valid), 1);
        end
    end

    // Reference: each output is the max of its 2x2 window after optional ReLU.
    function automatic int px(input frame_t f, input int r, input int c);
        int v;
        v = int'($signed(f[r * MW + c]));
        if (RELU && v < 0) v = 0;
        return v;
    endfunction

    function automatic int win_max(input frame_t f, input int r, input int c);
        int m;
        m = px(f, r - 1, c - 1);
        if (px(f, r - 1, c) > m) m = px(f, r - 1, c);
        if (px(f, r, c - 1) > m) m = px(f, r, c - 1);
        if (px(f, r, c) > m) m = px(f, r, c);
        return m;
    endfunction

    task automatic model_frame(input frame_t a, input frame_t b);
        for (int r = 1; r < MH; r++)
            for (int c = 1; c < MW; c++)
                exp_q.push_back({W'(win_max(a, r, c)), W'(win_max(b, r, c))});
    endtask

    task automatic send_pix(input logic [W-1:0] a, input logic [W-1:0] b);
        bit ok;
        int n;
        in_valid = 1'b1;
        in_ch1 = a;
        in_ch2 = b;
        ok = 1'b0;
        n = 0;
        while (!ok && n < 500) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) check("input_accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input frame_t a, input frame_t b, input bit gaps);
        for (int i = 0; i < NPIX; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send_pix(a[i], b[i]);
        end
    endtask

    task automatic wait_outputs(input int n);
        int k = 0;
        while (got_q.size() < n && k < 400) begin
            @(posedge clk);
            k++;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic compare_queues(input string nm);
        check({nm, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_ch1_%0d", nm, i), int'($signed(got_q[i][2*W-1:W])),
                  int'($signed(exp_q[i][2*W-1:W])));
            check($sformatf("%s_ch2_%0d", nm, i), int'($signed(got_q[i][W-1:0])),
                  int'($signed(exp_q[i][W-1:0])));
        end
    endtask

    task automatic clear_sb();
        got_q.delete();
        exp_q.delete();
        frames_seen = 0;
    endtask

    task automatic do_reset(input int cycles);
        reset_n = 1'b0;
        in_valid = 1'b0;
        repeat (cycles) begin @(posedge clk); #1; end
        reset_n = 1'b1;
    endtask

    task automatic fill(input int k, input int a[NPIX], input int b[NPIX],
                        input int ea[NOUT], input int eb[NOUT]);
        for (int i = 0; i < NPIX; i++) begin
            vecs[k].ch1[i] = W'(a[i]);
            vecs[k].ch2[i] = W'(b[i]);
        end
        for (int i = 0; i < NOUT; i++) begin
            vecs[k].exp1[i] = W'(ea[i]);
            vecs[k].exp2[i] = W'(eb[i]);
        end
    endtask

    frame_t basic_f, neg_f, fa, fb;

    initial begin
        int basic[NPIX] = '{5, -3, 7, 2, 1, -1, -4, 0, 6};
        int neg[NPIX]   = '{-1, -2, -3, -4, -5, -6, -7, -8, -9};
        int ext[NPIX]   = '{-2048, 2047, -2048, 2047, -2048, -2048, -2048, -2048, 2047};
        int low[NPIX]   = '{-2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048};
        int peak[NPIX]  = '{0, 0, 0, 0, 9, 0, 0, 0, 0};
        int ramp[NPIX]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        int e_basic[NOUT] = '{5, 7, 2, 6};
        int e_neg[NOUT]   = RELU ? '{0, 0, 0, 0} : '{-1, -2, -4, -5};
        int e_ext[NOUT]   = '{2047, 2047, 2047, 2047};
        int e_low[NOUT]   = RELU ? '{0, 0, 0, 0} : '{-2048, -2048, -2048, -2048};
        int e_peak[NOUT]  = '{9, 9, 9, 9};
        int e_ramp[NOUT]  = '{5, 6, 8, 9};

        fill(0, basic, neg, e_basic, e_neg);
        fill(1, ext, low, e_ext, e_low);
        fill(2, neg, basic, e_neg, e_basic);
        fill(3, peak, ramp, e_peak, e_ramp);
        basic_f = vecs[0].ch1;
        neg_f   = vecs[0].ch2;

        // Reset state, with the consumer ready so in_ready is gated by reset alone.
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_ch1", int'(out_ch1), 0);
        check("reset_out_ch2", int'(out_ch2), 0);
        check("reset_frame_done", int'(frame_done), 0);
        check("reset_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("post_reset_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // Table-driven frames, sent back to back with no reset in between.
        for (int v = 0; v < NV; v++) begin
            clear_sb();
            for (int i = 0; i < NOUT; i++) exp_q.push_back({vecs[v].exp1[i], vecs[v].exp2[i]});
            send_frame(vecs[v].ch1, vecs[v].ch2, 1'b0);
            wait_outputs(NOUT);
            compare_queues($sformatf("vec%0d", v));
            check($sformatf("vec%0d_frame_done", v), frames_seen, 1);
        end

        // Latency: first pooled result visible the cycle after the (1,1) pixel.
        clear_sb();
        for (int i = 0; i < 4; i++) send_pix(basic_f[i], neg_f[i]);
        @(negedge clk);
        check("latency_before_first", int'(out_valid), 0);
        @(posedge clk);
        #1;
        send_pix(basic_f[4], neg_f[4]);
        @(negedge clk);
        check("latency_out_valid", int'(out_valid), 1);
        check("latency_out_ch1", int'(out_ch1), 5);
        @(posedge clk);
        #1;
        for (int i = 5; i < NPIX; i++) send_pix(basic_f[i], neg_f[i]);
        wait_outputs(NOUT);

        // Backpressure: stall after the first output, then release.
        do_reset(1);
        clear_sb();
        ready_mode = 0;
        repeat (2) begin @(posedge clk); #1; end
        sender_done = 1'b0;
        fork
            begin
                send_frame(basic_f, neg_f, 1'b0);
                sender_done = 1'b1;
            end
        join_none
        for (int k = 0; k < 50 && !out_valid; k++) @(negedge clk);
        check("bp_first_valid", int'(out_valid), 1);
        repeat (4) begin
            @(negedge clk);
            check("bp_in_ready_low", int'(in_ready), 0);
            check("bp_out_ch1_held", int'(out_ch1), 5);
        end
        ready_mode = 1;
        for (int k = 0; k < 200 && !sender_done; k++) @(posedge clk);
        check("bp_sender_done", int'(sender_done), 1);
        for (int i = 0; i < NOUT; i++) exp_q.push_back({vecs[0].exp1[i], vecs[0].exp2[i]});
        wait_outputs(NOUT);
        compare_queues("backpressure");

        // Mid-frame reset discards the partial frame.
        clear_sb();
        for (int i = 0; i < 4; i++) send_pix(basic_f[i], neg_f[i]);
        do_reset(1);
        @(negedge clk);
        check("midreset_out_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        clear_sb();
        for (int i = 0; i < NOUT; i++) exp_q.push_back({vecs[0].exp1[i], vecs[0].exp2[i]});
        send_frame(basic_f, neg_f, 1'b0);
        wait_outputs(NOUT);
        compare_queues("midreset");
        check("midreset_frame_done", frames_seen, 1);

        // Back-to-back random frames with continuous in_valid.
        clear_sb();
        for (int i = 0; i < NPIX; i++) begin
            fa[i] = W'($urandom_range(0, 4095));
            fb[i] = W'($urandom_range(0, 4095));
        end
        model_frame(fa, fb);
        model_frame(fb, fa);
        send_frame(fa, fb, 1'b0);
        send_frame(fb, fa, 1'b0);
        wait_outputs(2 * NOUT);
        compare_queues("b2b");
        check("b2b_frame_done", frames_seen, 2);

        // Random data, input gaps and random backpressure.
        clear_sb();
        ready_mode = 2;
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < NPIX; i++) begin
                case ($urandom_range(0, 3))
                    0:       fa[i] = 12'h800;
                    1:       fa[i] = 12'h7FF;
                    default: fa[i] = W'($urandom_range(0, 4095));
                endcase
                fb[i] = W'($urandom_range(0, 4095));
            end
            model_frame(fa, fb);
            send_frame(fa, fb, 1'b1);
        end
        ready_mode = 1;
        wait_outputs(8 * NOUT);
        compare_queues("random");
        check("random_frame_done", frames_seen, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
